// File: rtl/param_dff_shift_reg.sv
// param_dff_shift_reg: WIDTH-bit register bank with a mode-selected operation
// (hold, load, logical shift, rotate, clear, preset). A shift counter pulses
// o_done on the edge that completes each WIDTH-bit serialisation.
// Optional feature macro: PARITY_OUT_EN adds a registered o_parity output
// (XOR reduction of q) that changes on the same edge as q.
module param_dff_shift_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
    localparam int              CW         = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_n,
    output logic             o_sout_l,
    output logic             o_sout_r,
    output logic [CW-1:0]    o_shift_cnt,
    output logic             o_done
`ifdef PARITY_OUT_EN
    ,
    output logic             o_parity
`endif
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHL    = 3'b010;
    localparam logic [2:0] MODE_SHR    = 3'b011;
    localparam logic [2:0] MODE_ROL    = 3'b100;
    localparam logic [2:0] MODE_ROR    = 3'b101;
    localparam logic [2:0] MODE_CLEAR  = 3'b110;
    localparam logic [2:0] MODE_PRESET = 3'b111;

    // The counter compare below and the shift slices rely on 2 <= WIDTH <= 32.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("param_dff_shift_reg: WIDTH must be in the range 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_shift_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_done_next;
    logic             w_is_shift;

    // Next-state data path and counter; done defaults low so it only pulses.
    always_comb begin
        w_q_next    = r_q;
        w_cnt_next  = r_shift_cnt;
        w_done_next = 1'b0;
        w_is_shift  = 1'b0;
        if (i_en) begin
            case (i_mode)
                MODE_HOLD: begin
                    w_q_next = r_q;
                end
                MODE_LOAD: begin
                    w_q_next   = i_d;
                    w_cnt_next = '0;
                end
                MODE_SHL: begin
                    w_q_next   = {r_q[WIDTH-2:0], i_sin_l};
                    w_is_shift = 1'b1;
                end
                MODE_SHR: begin
                    w_q_next   = {i_sin_r, r_q[WIDTH-1:1]};
                    w_is_shift = 1'b1;
                end
                MODE_ROL: begin
                    w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_is_shift = 1'b1;
                end
                MODE_ROR: begin
                    w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
                    w_is_shift = 1'b1;
                end
                MODE_CLEAR: begin
                    w_q_next   = '0;
                    w_cnt_next = '0;
                end
                MODE_PRESET: begin
                    w_q_next   = PRESET_VAL;
                    w_cnt_next = '0;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
            // Shifts and rotates share one counter; wrapping marks a full word.
            if (w_is_shift) begin
                if (r_shift_cnt == CW'(WIDTH - 1)) begin
                    w_cnt_next  = '0;
                    w_done_next = 1'b1;
                end else begin
                    w_cnt_next  = r_shift_cnt + CW'(1);
                end
            end
        end
    end

    // Register bank, counter and done pulse with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q         <= RESET_VAL;
            r_shift_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_shift_cnt <= w_cnt_next;
            r_done      <= w_done_next;
        end
    end

    // Complement output is purely combinational, one inverter per bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_q_n
            assign o_q_n[gi] = ~r_q[gi];
        end
    endgenerate

    assign o_q         = r_q;
    assign o_sout_l    = r_q[WIDTH-1];
    assign o_sout_r    = r_q[0];
    assign o_shift_cnt = r_shift_cnt;
    assign o_done      = r_done;

`ifdef PARITY_OUT_EN
    logic r_parity;

    // Parity is taken from the next-state value so it lands with q.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_parity <= ^RESET_VAL;
        end else begin
            r_parity <= ^w_q_next;
        end
    end

    assign o_parity = r_parity;
`endif

endmodule

// File: tb/tb_param_dff_shift_reg.sv
// Self-checking bench for param_dff_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Reference model tracks the register as an integer and the counter as a
// plain count of consecutive shifts since the last load/clear/preset/reset.
module tb_param_dff_shift_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] q;
    logic [7:0] q_n;
    logic       sout_l;
    logic       sout_r;
    logic [2:0] shift_cnt;
    logic       done;
`ifdef PARITY_OUT_EN
    logic       parity;
`endif

    param_dff_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .PRESET_VAL(8'hFF)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_mode     (mode),
        .i_d        (d),
        .i_sin_l    (sl),
        .i_sin_r    (sr),
        .o_q        (q),
        .o_q_n      (q_n),
        .o_sout_l   (sout_l),
        .o_sout_r   (sout_r),
        .o_shift_cnt(shift_cnt),
        .o_done     (done)
`ifdef PARITY_OUT_EN
        ,
        .o_parity   (parity)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_q;
    int         m_cnt;
    logic       m_done;

    // Drive one cycle of inputs, advance the model on the edge, sample #1 later.
    task automatic step(input logic e, input logic [2:0] md, input logic [7:0] dv,
                        input logic a, input logic b);
        int v;
        @(negedge clk);
        en = e; mode = md; d = dv; sl = a; sr = b;
        @(posedge clk);
        v = int'(m_q);
        if (e) begin
            case (md)
                3'd0: m_done = 1'b0;
                3'd1: begin v = int'(dv); m_cnt = 0; m_done = 1'b0; end
                3'd6: begin v = 0;        m_cnt = 0; m_done = 1'b0; end
                3'd7: begin v = 255;      m_cnt = 0; m_done = 1'b0; end
                default: begin
                    if (md == 3'd2) v = (v * 2) % 256 + int'(a);
                    if (md == 3'd3) v = v / 2 + (b ? 128 : 0);
                    if (md == 3'd4) v = (v * 2) % 256 + v / 128;
                    if (md == 3'd5) v = v / 2 + (v % 2) * 128;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == W) begin
                        m_cnt  = 0;
                        m_done = 1'b1;
                    end else begin
                        m_done = 1'b0;
                    end
                end
            endcase
        end else begin
            m_done = 1'b0;
        end
        m_q = 8'(v);
        #1;
    endtask

    task automatic model_reset();
        m_q = RV; m_cnt = 0; m_done = 1'b0;
    endtask

    task automatic test_reset();
        // Power-on reset.
        n_cmp++;
        if (q !== RV || q_n !== 8'h5A || shift_cnt !== 3'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_por: q=%h q_n=%h cnt=%0d done=%b, want q=a5 q_n=5a cnt=0 done=0",
                     q, q_n, shift_cnt, done);
        end
        n_cmp++;
        if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_sout: sout_l=%b sout_r=%b, want 1 1", sout_l, sout_r);
        end
        @(negedge clk); rst = 1'b0;
        // Load something, then assert clr between edges and see it take effect at once.
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        @(negedge clk); #2; rst = 1'b1; #1;
        model_reset();
        n_cmp++;
        if (q !== 8'hA5 || q_n !== 8'h5A || shift_cnt !== 3'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: q=%h q_n=%h cnt=%0d done=%b, want q=a5 q_n=5a cnt=0 done=0",
                     q, q_n, shift_cnt, done);
        end
        #1; rst = 1'b0;
    endtask

    task automatic test_load_hold();
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h3C || q_n !== 8'hC3) begin
            n_bad++;
            $display("FAIL load: q=%h q_n=%h, want 3c c3", q, q_n);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
            n_cmp++;
            if (q !== 8'h3C || done !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: q=%h done=%b, want 3c 0", i, q, done);
            end
        end
        step(1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h3C) begin
            n_bad++;
            $display("FAIL en_low_clear: q=%h, want 3c", q);
        end
    endtask

    task automatic test_shift_serial();
        step(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        n_cmp++;
        if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
            n_bad++;
            $display("FAIL sout_pre_shift: sout_l=%b sout_r=%b, want 1 1", sout_l, sout_r);
        end
        step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h02 || shift_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL shift_left: q=%h cnt=%0d, want 02 1", q, shift_cnt);
        end
        step(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (q !== 8'h81 || shift_cnt !== 3'd2) begin
            n_bad++;
            $display("FAIL shift_right: q=%h cnt=%0d, want 81 2", q, shift_cnt);
        end
    endtask

    task automatic test_rotate_done();
        step(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
            n_cmp++;
            if (done !== ((i == 7) || (i == 15)) || q !== m_q) begin
                n_bad++;
                $display("FAIL rotate[%0d]: q=%h done=%b, want q=%h done=%b",
                         i, q, done, m_q, (i == 7) || (i == 15));
            end
        end
        n_cmp++;
        if (q !== 8'h01 || shift_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL rotate_end: q=%h cnt=%0d, want 01 0", q, shift_cnt);
        end
    endtask

    task automatic test_counter_interrupt();
        for (int i = 0; i < 5; i++) step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (shift_cnt !== 3'd5) begin
            n_bad++;
            $display("FAIL cnt_five: cnt=%0d, want 5", shift_cnt);
        end
        step(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        n_cmp++;
        if (shift_cnt !== 3'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL cnt_load_clear: cnt=%0d done=%b, want 0 0", shift_cnt, done);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2 == 0) ? 3'd3 : 3'd5, 8'h00, 1'b0, 1'b1);
            n_cmp++;
            if (done !== (i == 7)) begin
                n_bad++;
                $display("FAIL mixed_done[%0d]: done=%b, want %b", i, done, i == 7);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        @(negedge clk); #2; rst = 1'b1; #1;
        model_reset();
        n_cmp++;
        if (shift_cnt !== 3'd0 || q !== 8'hA5) begin
            n_bad++;
            $display("FAIL cnt_async_clr: cnt=%0d q=%h, want 0 a5", shift_cnt, q);
        end
        #1; rst = 1'b0;
    endtask

    task automatic test_clear_preset();
        step(1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'hFF) begin
            n_bad++;
            $display("FAIL preset: q=%h, want ff", q);
        end
`ifdef PARITY_OUT_EN
        n_cmp++;
        if (parity !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_preset: parity=%b, want 0", parity);
        end
`endif
        step(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h00 || q_n !== 8'hFF) begin
            n_bad++;
            $display("FAIL clear: q=%h q_n=%h, want 00 ff", q, q_n);
        end
        step(1'b1, 3'd1, 8'h07, 1'b0, 1'b0);
`ifdef PARITY_OUT_EN
        n_cmp++;
        if (parity !== 1'b1 || q !== 8'h07) begin
            n_bad++;
            $display("FAIL parity_load: parity=%b q=%h, want 1 07", parity, q);
        end
`endif
    endtask

    task automatic test_random();
        logic       e;
        logic [2:0] md;
        for (int i = 0; i < 300; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            md = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(2, 5));
            step(e, md, 8'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if (q !== m_q || q_n !== ~m_q || sout_l !== m_q[7] || sout_r !== m_q[0] ||
                shift_cnt !== 3'(m_cnt) || done !== m_done) begin
                n_bad++;
                $display("FAIL random[%0d]: en=%b mode=%0d q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                         i, e, md, q, shift_cnt, done, m_q, m_cnt, m_done);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sl = 1'b0; sr = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_load_hold();
        test_shift_serial();
        test_rotate_done();
        test_counter_interrupt();
        test_clear_preset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
